// File: rtl/minirisc_pkg.sv
// minirisc_pkg: shared fetch types and constants for the MiniRISC front end.
package minirisc_pkg;
    typedef enum logic [1:0] {REQ, WAIT, VALID, HALT} fetch_state_t;
    localparam int INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: next-PC mux, priority hold (halt) > aligned redirect > step by PC_STEP.
module fetch_pc_gen
    import minirisc_pkg::*;
#(
    parameter int DATA_W = INSTR_W
) (
    input  logic [DATA_W-1:0] pc,
    input  logic              hold,
    input  logic              redirect,
    input  logic [DATA_W-1:0] redirect_pc,
    input  logic              step,
    output logic [DATA_W-1:0] next_pc
);
    always_comb begin
        next_pc = hold ? pc
                : redirect ? (redirect_pc & ~DATA_W'(3))
                : step ? pc + DATA_W'(PC_STEP)
                : pc;
    end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: MiniRISC fetch sequencer REQ -> WAIT -> VALID with redirect/halt.
// Define FETCH_PERF_EN to add the fetch_count handshake counter port.
module fetch_controller
    import minirisc_pkg::*;
#(
    parameter int                DATA_W   = INSTR_W,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [DATA_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [DATA_W-1:0] fetch_count
`endif
);
    fetch_state_t      state, state_n;
    logic [DATA_W-1:0] pc, next_pc;
    logic              hs;

    assign hs        = (state == VALID) && out_ready;
    assign imem_en   = (state == REQ);
    assign imem_addr = pc;

    always_comb begin
        state_n = (halt || state == HALT) ? HALT
                : redirect_valid ? REQ
                : (state == REQ) ? WAIT
                : (state == WAIT) ? VALID
                : hs ? REQ
                : state;
    end

    fetch_pc_gen #(.DATA_W(DATA_W)) u_pc_gen (
        .pc          (pc),
        .hold        (halt || state == HALT),
        .redirect    (redirect_valid),
        .redirect_pc (redirect_pc),
        .step        (hs),
        .next_pc     (next_pc)
    );

    // A redirect during WAIT leaves WAIT without capturing, dropping the stale word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= REQ;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= '0;
            halted    <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= next_pc;
            out_valid <= (state_n == VALID);
            halted    <= (state_n == HALT);
            if (state == WAIT && state_n == VALID) begin
                out_pc    <= pc;
                out_instr <= imem_rdata;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            fetch_count <= '0;
        else if (hs && !halt)
            fetch_count <= fetch_count + DATA_W'(1);
    end
`endif
endmodule
